// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI-Lite transaction, one response out.
// Optional saturating error counter (err_count) enabled by defining AXIL_MASTER_CMD_ERR_CNT_EN.
module axil_master_cmd #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [STRB_WIDTH-1:0]   cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

  if ((DATA_WIDTH % 8) != 0 || STRB_WIDTH != DATA_WIDTH / 8 || ERR_CNT_WIDTH < 1) begin : g_param_check
    $error("axil_master_cmd: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_RD_A,
    S_RD_D,
    S_RSP
  } state_t;

  state_t state_q, state_d;

  logic                  aw_done_q, w_done_q;
  logic                  aw_fin, w_fin;
  logic                  cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign rsp_hs = rsp_valid & rsp_ready;
  assign aw_hs  = m_axil_awvalid & m_axil_awready;
  assign w_hs   = m_axil_wvalid & m_axil_wready;
  assign b_hs   = m_axil_bvalid & m_axil_bready;
  assign ar_hs  = m_axil_arvalid & m_axil_arready;
  assign r_hs   = m_axil_rvalid & m_axil_rready;

  // A write channel is finished once its handshake has happened, now or in an earlier cycle.
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = '0;
  assign m_axil_arprot = '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_hs) state_d = cmd_write ? S_WR : S_RD_A;
      S_WR:   if (aw_fin && w_fin) state_d = S_WR_B;
      S_WR_B: if (b_hs) state_d = S_RSP;
      S_RD_A: if (ar_hs) state_d = S_RD_D;
      S_RD_D: if (r_hs) state_d = S_RSP;
      S_RSP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are registered images of the next state, so no valid is combinational on a ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_ready      <= 1'b1;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid      <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
    end else begin
      cmd_ready      <= (state_d == S_IDLE);
      m_axil_awvalid <= (state_d == S_WR) & ~aw_fin;
      m_axil_wvalid  <= (state_d == S_WR) & ~w_fin;
      m_axil_bready  <= (state_d == S_WR_B);
      m_axil_arvalid <= (state_d == S_RD_A);
      m_axil_rready  <= (state_d == S_RD_D);
      rsp_valid      <= (state_d == S_RSP);
      aw_done_q      <= (state_q == S_WR) & aw_fin;
      w_done_q       <= (state_q == S_WR) & w_fin;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      if (b_hs) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axil_bresp;
      end else if (r_hs) begin
        rsp_write <= 1'b0;
        rsp_rdata <= m_axil_rdata;
        rsp_resp  <= m_axil_rresp;
      end
    end
  end

`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
  logic err_evt;

  assign err_evt = (b_hs && (m_axil_bresp != 2'b00)) || (r_hs && (m_axil_rresp != 2'b00));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (err_evt && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_master_cmd.sv
// Scoreboard bench for axil_master_cmd: directed commands against a configurable AXI-Lite slave model.
// Define AXIL_MASTER_CMD_ERR_CNT_EN to also exercise err_count.
module tb_axil_master_cmd;

  typedef struct {
    bit          write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          a_lat;
    int          d_lat;
    int          hold;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_cmd_cyc = 0, last_a_cyc = 0, last_d_cyc = 0, last_rsp_hs_cyc = 0;
  exp_t sb[$];

  // slave configuration and the command currently expected on the AXI side
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [8:0]  cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  logic [31:0] mem [128];

  axil_master_cmd #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(9),
    .STRB_WIDTH(4),
    .ERR_CNT_WIDTH(8)
  ) dut (
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
    .err_count(err_count),
`endif
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(bit w, logic [31:0] rd, logic [1:0] rs, int lat, int al, int dl, int hold);
    exp_t e;
    e.write = w; e.rdata = rd; e.resp = rs;
    e.lat = lat; e.a_lat = al; e.d_lat = dl; e.hold = hold;
    return e;
  endfunction

  task automatic set_slave(input int awd, input int wd, input int ard, input int rd,
                           input logic [1:0] bcfg, input logic [1:0] rcfg);
    aw_delay = awd; w_delay = wd; ar_delay = ard; r_delay = rd;
    bresp_cfg = bcfg; rresp_cfg = rcfg;
  endtask

  task automatic issue(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input exp_t e, input bit after_rsp);
    int n;
    int hs;
    @(negedge clk);
    cur_addr = addr; cur_wdata = wd; cur_wstrb = st;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", cmd_ready, 1);
    if (cmd_ready) begin
      hs = cyc + 1;
      last_cmd_cyc = hs;
      if (after_rsp) chk("accept_cycle_after_rsp", hs, last_rsp_hs_cyc + 1);
    end else begin
      void'(sb.pop_back());
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid || cmd_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (sb.size() != 0) || rsp_valid, 0);
    @(negedge clk);
  endtask

  // response monitor / scoreboard checker
  initial begin
    exp_t cur;
    bit   active = 0;
    bit   pend = 0;
    int   wcnt = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        active = 0; pend = 0; wcnt = 0; rsp_ready = 1'b0;
      end else if (pend) begin
        pend = 0; active = 0; rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("idle_after_rsp", cmd_ready, 1);
      end else if (rsp_valid) begin
        if (!active) begin
          chk("rsp_expected", sb.size() != 0, 1);
          if (sb.size() != 0) cur = sb.pop_front();
          else cur = mk(0, '0, '0, -1, -1, -1, 0);
          active = 1; wcnt = 0;
          if (cur.lat >= 0) begin
            chk("rsp_latency", cyc + 1 - last_cmd_cyc, cur.lat);
            chk("addr_hs_latency", last_a_cyc - last_cmd_cyc, cur.a_lat);
            chk("data_hs_latency", last_d_cyc - last_cmd_cyc, cur.d_lat);
          end
        end
        chk("rsp_write", rsp_write, cur.write);
        chk("rsp_rdata", rsp_rdata, cur.rdata);
        chk("rsp_resp", rsp_resp, cur.resp);
        chk("cmd_ready_busy", cmd_ready, 0);
        if (wcnt < cur.hold) begin
          wcnt++;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
          pend = 1;
          last_rsp_hs_cyc = cyc + 1;
        end
      end
    end
  end

  // AXI-Lite slave model; a handshake predicted at one falling edge completes on the next rising edge
  initial begin
    bit         aw_nx = 0, w_nx = 0, ar_nx = 0, b_nx = 0, r_nx = 0;
    bit         aw_d = 0, w_d = 0, ar_d = 0;
    int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [8:0] a_aw = '0, a_ar = '0;
    logic [31:0] c_wd = '0;
    logic [3:0]  c_st = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0; bresp = '0; rresp = '0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        aw_nx = 0; w_nx = 0; ar_nx = 0; b_nx = 0; r_nx = 0;
        aw_d = 0; w_d = 0; ar_d = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (b_nx) begin
          bvalid = 1'b0;
          chk("bready_drop", bready, 0);
          aw_d = 0; w_d = 0; aw_cnt = 0; w_cnt = 0;
        end
        if (r_nx) begin
          rvalid = 1'b0;
          chk("rready_drop", rready, 0);
          ar_d = 0; ar_cnt = 0; r_cnt = 0;
        end
        if (aw_nx) begin
          awready = 1'b0; aw_d = 1;
          chk("awvalid_drop", awvalid, 0);
        end else if (awvalid && !aw_d) begin
          chk("awaddr", awaddr, cur_addr);
          chk("awprot", awprot, 0);
          if (aw_cnt >= aw_delay) begin awready = 1'b1; a_aw = awaddr; end
          else aw_cnt++;
        end
        if (w_nx) begin
          wready = 1'b0; w_d = 1;
          chk("wvalid_drop", wvalid, 0);
        end else if (wvalid && !w_d) begin
          chk("wdata", wdata, cur_wdata);
          chk("wstrb", wstrb, cur_wstrb);
          if (w_cnt >= w_delay) begin wready = 1'b1; c_wd = wdata; c_st = wstrb; end
          else w_cnt++;
        end
        if (ar_nx) begin
          arready = 1'b0; ar_d = 1;
          chk("arvalid_drop", arvalid, 0);
        end else if (arvalid && !ar_d) begin
          chk("araddr", araddr, cur_addr);
          chk("arprot", arprot, 0);
          if (ar_cnt >= ar_delay) begin arready = 1'b1; a_ar = araddr; end
          else ar_cnt++;
        end
        if (aw_d && w_d && !bvalid) begin
          bvalid = 1'b1; bresp = bresp_cfg;
          for (int i = 0; i < 4; i++)
            if (c_st[i]) mem[a_aw[8:2]][8*i +: 8] = c_wd[8*i +: 8];
        end
        if (ar_d && !rvalid) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1'b1; rdata = mem[a_ar[8:2]]; rresp = rresp_cfg;
          end else r_cnt++;
        end
        if (bready) chk("bready_after_aw_w", aw_d && w_d, 1);
        if (rready) chk("rready_after_ar", ar_d, 1);
        aw_nx = awvalid && awready;
        w_nx  = wvalid && wready;
        ar_nx = arvalid && arready;
        b_nx  = bvalid && bready;
        r_nx  = rvalid && rready;
        if (aw_nx || ar_nx) last_a_cyc = cyc + 1;
        if (b_nx || r_nx) last_d_cyc = cyc + 1;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // zero-wait write then read-back
    set_slave(0, 0, 0, 0, 2'b00, 2'b00);
    issue(1, 9'h010, 32'hDEADBEEF, 4'hF, mk(1, 32'h0, 2'b00, 3, 1, 2, 0), 0);
    wait_idle();
    issue(0, 9'h010, 32'h0, 4'h0, mk(0, 32'hDEADBEEF, 2'b00, 3, 1, 2, 0), 0);
    wait_idle();

    // wready delayed 3 cycles, partial strobes
    set_slave(0, 3, 0, 0, 2'b00, 2'b00);
    issue(1, 9'h024, 32'h12345678, 4'h5, mk(1, 32'h0, 2'b00, 6, 1, 5, 0), 0);
    wait_idle();
    set_slave(0, 0, 0, 0, 2'b00, 2'b00);
    issue(0, 9'h024, 32'h0, 4'h0, mk(0, 32'h00340078, 2'b00, 3, 1, 2, 0), 0);
    wait_idle();

    // awready late (W completes first), top address, upper strobes
    set_slave(2, 0, 0, 0, 2'b00, 2'b00);
    issue(1, 9'h1FC, 32'hA5A50F0F, 4'hC, mk(1, 32'h0, 2'b00, 5, 3, 4, 0), 0);
    wait_idle();
    set_slave(0, 0, 1, 2, 2'b00, 2'b00);
    issue(0, 9'h1FC, 32'h0, 4'h0, mk(0, 32'hA5A50000, 2'b00, 6, 2, 5, 0), 0);
    wait_idle();

    // rsp_ready held low 5 cycles while the next command is already waiting
    set_slave(0, 0, 0, 0, 2'b00, 2'b00);
    issue(0, 9'h010, 32'h0, 4'h0, mk(0, 32'hDEADBEEF, 2'b00, 3, 1, 2, 5), 0);
    issue(1, 9'h030, 32'h0BADF00D, 4'hF, mk(1, 32'h0, 2'b00, -1, -1, -1, 0), 1);
    wait_idle();

    // error responses pass through unchanged
    set_slave(0, 0, 0, 0, 2'b00, 2'b10);
    issue(0, 9'h010, 32'h0, 4'h0, mk(0, 32'hDEADBEEF, 2'b10, 3, 1, 2, 0), 0);
    wait_idle();
    issue(0, 9'h030, 32'h0, 4'h0, mk(0, 32'h0BADF00D, 2'b10, 3, 1, 2, 0), 0);
    wait_idle();
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
    chk("err_count_two", err_count, 2);
`endif
    set_slave(0, 0, 0, 0, 2'b01, 2'b00);
    issue(1, 9'h040, 32'h00000011, 4'h1, mk(1, 32'h0, 2'b01, 3, 1, 2, 0), 0);
    wait_idle();
    set_slave(0, 0, 0, 0, 2'b11, 2'b00);
    issue(1, 9'h044, 32'h00000022, 4'h1, mk(1, 32'h0, 2'b11, 3, 1, 2, 0), 0);
    wait_idle();
    set_slave(0, 0, 0, 0, 2'b00, 2'b00);
    issue(0, 9'h040, 32'h0, 4'h0, mk(0, 32'h00000011, 2'b00, 3, 1, 2, 0), 0);
    wait_idle();
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
    chk("err_count_four", err_count, 4);
    set_slave(0, 0, 0, 0, 2'b00, 2'b01);
    for (int i = 0; i < 300; i++) begin
      issue(0, 9'h044, 32'h0, 4'h0, mk(0, 32'h00000022, 2'b01, -1, -1, -1, 0), 0);
      wait_idle();
      if (i == 250) chk("err_count_255", err_count, 255);
    end
    chk("err_count_saturated", err_count, 255);
`endif

    // reset while AW/W are pending
    set_slave(20, 20, 0, 0, 2'b00, 2'b00);
    @(negedge clk);
    cur_addr = 9'h050; cur_wdata = 32'hCAFEF00D; cur_wstrb = 4'hF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h050; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    chk("rst_test_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_awvalid", awvalid, 1);
    chk("pre_rst_wvalid", wvalid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_awvalid", awvalid, 0);
    chk("async_rst_wvalid", wvalid, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
`ifdef AXIL_MASTER_CMD_ERR_CNT_EN
    chk("async_rst_err_count", err_count, 0);
`endif
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
      chk("cmd_ready_after_rst", cmd_ready, 1);
    end

    set_slave(0, 0, 0, 0, 2'b00, 2'b00);
    issue(0, 9'h010, 32'h0, 4'h0, mk(0, 32'hDEADBEEF, 2'b00, 3, 1, 2, 0), 0);
    wait_idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
